// File: rtl/alu_seq_unit_if.sv
// Handshake and result bundle between the EX-stage issue logic and alu_seq_unit.
// Master drives the operation and consumes the result; slave is the ALU.
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] port_o;
  logic [WIDTH-1:0] port_hi;
  logic             z_fl;
  logic             n_fl;
  logic             o_fl;
  logic             dz_fl;
  logic             bad_op;

  modport master (
    output in_valid, op, port_a, port_b, abort, out_ready,
    input  in_ready, out_valid, port_o, port_hi, z_fl, n_fl, o_fl, dz_fl, bad_op
  );

  modport slave (
    input  in_valid, op, port_a, port_b, abort, out_ready,
    output in_ready, out_valid, port_o, port_hi, z_fl, n_fl, o_fl, dz_fl, bad_op
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// shift-add multiply and restoring divide, behind valid/ready handshakes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an op
// BUSY  | MULU/DIVU iterating, one bit per cycle, cnt_q counts down to 1
// DONE  | out_valid=1, result held until consumed or aborted
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic          CLK,
  input  logic          RST,
  alu_seq_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor
  logic [WIDTH-1:0]   work_hi_q, work_hi_d; // product high / partial remainder
  logic [WIDTH-1:0]   work_lo_q, work_lo_d; // multiplier bits / quotient bits
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_o_q, res_o_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               z_q, z_d, n_q, n_d, ov_q, ov_d, dz_q, dz_d, bad_q, bad_d;

  // Single-cycle result, evaluated straight off the input ports at accept.
  logic [WIDTH-1:0]   sc_o, sc_hi, sc_sum, sc_dif;
  logic               sc_ov, sc_dz, sc_bad;
  logic [CNT_W-2:0]   shamt;

  // One shift-add / restore-subtract step on the working registers.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_hi_nx, div_lo_nx;
  logic [WIDTH-1:0]   fin_o;

  assign shamt  = bus.port_b[CNT_W-2:0];
  assign sc_sum = bus.port_a + bus.port_b;
  assign sc_dif = bus.port_a - bus.port_b;

  assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};

  // Shifted remainder is < 2*divisor, so bit WIDTH of the difference is a clean borrow.
  assign div_sh    = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_diff  = div_sh - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_hi_nx = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo_nx = {work_lo_q[WIDTH-2:0], div_ok};

  // Decode and compute the latency-1 operations.
  always_comb begin
    sc_o   = '0;
    sc_hi  = '0;
    sc_ov  = 1'b0;
    sc_dz  = 1'b0;
    sc_bad = 1'b0;
    case (bus.op)
      OP_SLL:  sc_o = bus.port_a << shamt;
      OP_SRL:  sc_o = bus.port_a >> shamt;
      OP_ADD: begin
        sc_o  = sc_sum;
        sc_ov = (bus.port_a[WIDTH-1] == bus.port_b[WIDTH-1]) &&
                (sc_sum[WIDTH-1] != bus.port_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_o  = sc_dif;
        sc_ov = (bus.port_a[WIDTH-1] != bus.port_b[WIDTH-1]) &&
                (sc_dif[WIDTH-1] != bus.port_a[WIDTH-1]);
      end
      OP_AND:  sc_o = bus.port_a & bus.port_b;
      OP_OR:   sc_o = bus.port_a | bus.port_b;
      OP_XOR:  sc_o = bus.port_a ^ bus.port_b;
      OP_NOR:  sc_o = ~(bus.port_a | bus.port_b);
      OP_SLT:  sc_o = {{(WIDTH-1){1'b0}}, ($signed(bus.port_a) < $signed(bus.port_b))};
      OP_SLTU: sc_o = {{(WIDTH-1){1'b0}}, (bus.port_a < bus.port_b)};
      OP_MULU: sc_o = '0;  // always iterative, never takes this path
      OP_DIVU: begin       // only reached with a zero divisor
        sc_o  = '1;
        sc_hi = bus.port_a;
        sc_dz = 1'b1;
      end
      default: sc_bad = 1'b1;
    endcase
  end

  // Next-state, iteration and result-capture logic.
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    cnt_d     = cnt_q;
    res_o_d   = res_o_q;
    res_hi_d  = res_hi_q;
    z_d       = z_q;
    n_d       = n_q;
    ov_d      = ov_q;
    dz_d      = dz_q;
    bad_d     = bad_q;
    fin_o     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.abort) begin
          if (bus.op == OP_MULU) begin
            state_d   = S_BUSY;
            is_div_d  = 1'b0;
            opnd_d    = bus.port_a;
            work_hi_d = '0;
            work_lo_d = bus.port_b;
            cnt_d     = CNT_W'(WIDTH);
          end else if (bus.op == OP_DIVU && bus.port_b != '0) begin
            state_d   = S_BUSY;
            is_div_d  = 1'b1;
            opnd_d    = bus.port_b;
            work_hi_d = '0;
            work_lo_d = bus.port_a;
            cnt_d     = CNT_W'(WIDTH);
          end else begin
            state_d  = S_DONE;
            fin_o    = sc_o;
            res_o_d  = sc_o;
            res_hi_d = sc_hi;
            z_d      = (fin_o == '0);
            n_d      = fin_o[WIDTH-1];
            ov_d     = sc_ov;
            dz_d     = sc_dz;
            bad_d    = sc_bad;
          end
        end
      end

      S_BUSY: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          work_hi_d = is_div_q ? div_hi_nx : mul_hi_nx;
          work_lo_d = is_div_q ? div_lo_nx : mul_lo_nx;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            fin_o    = work_lo_d;
            res_o_d  = work_lo_d;
            res_hi_d = work_hi_d;
            z_d      = (fin_o == '0);
            n_d      = fin_o[WIDTH-1];
            ov_d     = !is_div_q && (work_hi_d != '0);
            dz_d     = 1'b0;
            bad_d    = 1'b0;
          end
        end
      end

      S_DONE: begin
        if (bus.abort || bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      cnt_q     <= '0;
      res_o_q   <= '0;
      res_hi_q  <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      ov_q      <= 1'b0;
      dz_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      opnd_q    <= opnd_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      cnt_q     <= cnt_d;
      res_o_q   <= res_o_d;
      res_hi_q  <= res_hi_d;
      z_q       <= z_d;
      n_q       <= n_d;
      ov_q      <= ov_d;
      dz_q      <= dz_d;
      bad_q     <= bad_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.port_o    = res_o_q;
  assign bus.port_hi   = res_hi_q;
  assign bus.z_fl      = z_q;
  assign bus.n_fl      = n_q;
  assign bus.o_fl      = ov_q;
  assign bus.dz_fl     = dz_q;
  assign bus.bad_op    = bad_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed corner cases plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_seq_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic [31:0] hi;
    logic [4:0]  fl;   // {z, n, o, dz, bad}
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      s;
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ov, dz, bad;
    e.o = 0; e.hi = 0; e.lat = 1; ov = 0; dz = 0; bad = 0;
    sh = b[4:0];
    case (op)
      0: e.o = a << sh;
      1: e.o = a >> sh;
      2: begin
        s   = longint'($signed(a)) + longint'($signed(b));
        e.o = a + b;
        ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3: begin
        s   = longint'($signed(a)) - longint'($signed(b));
        e.o = a - b;
        ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4: e.o = a & b;
      5: e.o = a | b;
      6: e.o = a ^ b;
      7: e.o = ~(a | b);
      8: e.o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: e.o = (a < b) ? 32'd1 : 32'd0;
      10: begin
        p     = {32'd0, a} * {32'd0, b};
        e.o   = p[31:0];
        e.hi  = p[63:32];
        ov    = (e.hi != 0);
        e.lat = 33;
      end
      11: begin
        if (b == 0) begin
          e.o = 32'hFFFF_FFFF; e.hi = a; dz = 1;
        end else begin
          e.o = a / b; e.hi = a % b; e.lat = 33;
        end
      end
      default: bad = 1;
    endcase
    e.fl = {(e.o == 0), e.o[31], ov, dz, bad};
    return e;
  endfunction

  function automatic logic [4:0] dut_fl();
    return {bus.z_fl, bus.n_fl, bus.o_fl, bus.dz_fl, bus.bad_op};
  endfunction

  // Issue one op, check latency and result, apply back-pressure hold_cyc cycles, then consume.
  task automatic do_op(input string tag, input int unsigned op, input logic [31:0] a,
                       input logic [31:0] b, input int hold_cyc);
    exp_t e;
    int   edges;
    e = model(op, a, b);
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.op = op[3:0]; bus.port_a = a; bus.port_b = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom_range(0, 15)); bus.port_a = $urandom; bus.port_b = $urandom;
    chk({tag, "_nordy"}, 64'(bus.in_ready), 64'd0);
    edges = 1;
    while (!bus.out_valid && edges < 80) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_lat"}, 64'(edges), 64'(e.lat));
    chk({tag, "_o"},   64'(bus.port_o),  64'(e.o));
    chk({tag, "_hi"},  64'(bus.port_hi), 64'(e.hi));
    chk({tag, "_fl"},  64'(dut_fl()),    64'(e.fl));
    bus.in_valid = 1'b1;   // must be ignored while a result is pending
    for (int i = 0; i < hold_cyc; i++) @(negedge clk);
    chk({tag, "_hold"}, {bus.port_o, bus.port_hi}, {e.o, e.hi});
    chk({tag, "_hold_st"}, {59'd0, bus.out_valid, bus.in_ready, dut_fl()}, {59'd0, 1'b1, 1'b0, e.fl});
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_cons"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.in_valid = 0; bus.op = 0; bus.port_a = 0; bus.port_b = 0;
    bus.abort = 0; bus.out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", {bus.port_o, bus.port_hi}, 64'd0);
    chk("rst_ctl", {57'd0, bus.in_ready, bus.out_valid, dut_fl()}, {57'd0, 1'b1, 1'b0, 5'd0});
    rst = 1'b0;

    // directed corner cases
    do_op("add_ovf", 2,  32'h7FFF_FFFF, 32'h1, 0);
    do_op("mul_max", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op("div_7",   11, 32'd100, 32'd7, 0);
    do_op("div_0",   11, 32'd100, 32'd0, 0);
    do_op("sub_bp",  3,  32'd5, 32'd5, 10);
    do_op("slt",     8,  32'hFFFF_FFFF, 32'd0, 0);
    do_op("sltu",    9,  32'hFFFF_FFFF, 32'd0, 0);
    do_op("sll",     0,  32'd1, 32'h25, 0);
    do_op("badop",   14, 32'h1234, 32'h5678, 0);
    do_op("mul_0",   10, 32'h0, 32'h1234_5678, 0);
    do_op("div_big", 11, 32'h5, 32'hFFFF_FFFF, 0);

    // abort has priority over in_valid in IDLE
    @(negedge clk);
    bus.in_valid = 1; bus.abort = 1; bus.op = 2; bus.port_a = 1; bus.port_b = 1;
    @(negedge clk);
    bus.in_valid = 0; bus.abort = 0;
    chk("abort_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

    // abort during MULU, cycle 10
    bus.in_valid = 1; bus.op = 10; bus.port_a = 32'hFFFF_FFFF; bus.port_b = 32'h3;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (9) @(negedge clk);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    chk("abort_busy", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("abort_noval", 64'(seen), 64'd0);
    end

    // abort while a result is pending drops it
    bus.in_valid = 1; bus.op = 2; bus.port_a = 3; bus.port_b = 4;
    @(negedge clk);
    bus.in_valid = 0;
    chk("abort_done_pre", 64'(bus.out_valid), 64'd1);
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
    chk("abort_done", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

    // reset in the middle of a divide
    bus.in_valid = 1; bus.op = 11; bus.port_a = 100; bus.port_b = 7;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_ctl", {57'd0, bus.in_ready, bus.out_valid, dut_fl()}, {57'd0, 1'b1, 1'b0, 5'd0});
    chk("rst_mid_res", {bus.port_o, bus.port_hi}, 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("rst_mid_noval", 64'(seen), 64'd0);
    end

    // randomized ops
    for (int k = 0; k < 60; k++) begin
      int unsigned op;
      logic [31:0] a, b;
      op = $urandom_range(0, 15);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 0;
        1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        2: a = b;
        default: ;
      endcase
      do_op("rnd", op, a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
